out_unit: RTL
=============

Name: out_unit

Overview:
- MIX character output unit; the transmit counterpart of the IN unit.
- On an OUT instruction it fetches one block of words from CPU memory over a request/load handshake and unpacks each 30-bit word into five 6-bit MIX characters, MSB first.
- Each character is converted to ASCII and sent on the serial line through a UART transmitter. CR LF follows every block.
- Sits beside the IN unit on the CPU I/O bus: unit 19 = terminal (14 words/block), unit 18 = printer (24 words/block).

Parameters:
- CLKS_PER_BIT, 104, clocks per UART bit; passed to the TX sub-module.
- TERM_UNIT, 19, device number for the terminal.
- PRINT_UNIT, 18, device number for the printer.
- TERM_WORDS, 14, block length in words for the terminal.
- PRINT_WORDS, 24, block length in words for the printer.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle OUT strobe from the CPU
- field  in  6  unit number (F field), sampled with start
- addressin  in  12  block start address (M), sampled with start
- addressout  out  12  memory address of the word being requested
- request  out  1  unit wants the word at addressout
- load  in  1  CPU strobe: data is valid this cycle; answers request
- in  in  30  memory word (5 x 6-bit bytes)
- stop  out  1  one-cycle pulse: the CPU may resume
- busy  out  1  unit is working (JBUS/JRED status)
- tx  out  1  UART serial output, idles high

Behaviour:
- Reset is asynchronous and active-high and clears all state:
  - busy=0, request=0, stop=0, addressout=0, tx=1, second-block flag=0, FSM=IDLE.
- Start, unit idle (start & ~busy):
  - Latch unit<=field, addressout<=addressin.
  - busy<=1 next cycle; stop pulses the next cycle (CPU continues while output runs).
- Start, unit busy (start & busy):
  - Latch next_addr<=addressin and set second-block flag (pend). No stop pulse, so the CPU stays stalled.
  - At end of the current block: addressout<=next_addr, pend<=0, stop pulses once, busy stays 1 and the second block runs.
  - A third start while pend=1 is ignored.
- Block length: 14 words if unit==TERM_UNIT; 24 if unit==PRINT_UNIT. Any other unit completes immediately: no request, no tx, busy drops after one cycle.
- FSM states: IDLE, FETCH, SEND, CR, LF, DONE.
  - FETCH: request=1. When load=1: word<=in, request<=0 in the next cycle, addressout+1 (12-bit wrap 4095->0), char count<=0, go to SEND.
  - SEND: present char word[29:24] converted to ASCII to the TX sub-module.
    - On TX accept: shift word left 6 and increment char count.
    - After the 5th char: word count+1. If word count == block length, go to CR; else go to FETCH.
  - CR: send 0x0D, then LF: send 0x0A, then DONE.
  - DONE: if pend, reload addressout and go to FETCH; else busy<=0 and go to IDLE.
- load while request=0 is ignored. request holds until load; there is no timeout.
- MIX -> ASCII mapping:
  - 0 -> space; 1-9 -> A-I; 11-19 -> J-R; 22-29 -> S-Z; 30-39 -> '0'-'9'.
  - 40 . ; 41 , ; 42 ( ; 43 ) ; 44 + ; 45 - ; 46 * ; 47 / ; 48 = ; 49 $ ; 50 < ; 51 > ; 52 @ ; 53 ; ; 54 : ; 55 '
  - 10, 20, 21, 56-63 -> space (0x20).
- TX sub-module: 8N1, LSB first. Handshake is valid/ready.
  - ready=1 only when idle; data is accepted on the cycle valid & ready.
  - Next byte can be accepted one cycle after the stop bit ends.
- Reset mid-block aborts at once: tx forced high, a partial frame is dropped, no stop pulse.

Decomposition:
- Shared package holds:
  - unit number constants (TERM_UNIT, PRINT_UNIT);
  - block-length constants;
  - MIX->ASCII table as a function (inverse of the IN-unit table);
  - ASCII CR/LF constants.
- One sub-module, uart_tx (clk, reset, data[7:0], valid, ready, tx). It is the sibling of the IN unit's UART receiver.

Test Plan:
- Reset mid-SEND -> tx=1 and busy=0 within 1 cycle; no stop pulse; next start behaves normally.
- start, field=19, addressin=100; answer each request with load one cycle later. Word 0 = 0x1083780 (chars 1,2,3,30,0), other words 0 -> tx bytes 0x41 0x42 0x43 0x30 0x20, then 65 x 0x20, then 0x0D 0x0A. Requested addresses run 100..113. stop pulses once, right after start. busy falls after LF.
- field=18, addressin=4090 -> 24 requests, addresses 4090..4095 then 0..17; 122 bytes total on tx.
- Second start (addressin=200) during the first block -> no stop until the first block's LF; then one stop pulse, requests begin at 200, busy stays high throughout.
- Word with chars 10, 20, 52, 55, 63 -> tx 0x20 0x20 0x40 0x27 0x20.
- field=5 -> no request, tx stays high, busy high for 1 cycle then 0, stop pulses once.

Source files
------------

// File: rtl/out_unit_pkg.sv
// Shared definitions for the MIX character output unit.
// Unit numbers, block lengths, FSM state codes, ASCII control codes and
// the MIX-to-ASCII character table.
package out_unit_pkg;

   localparam int UNIT_TERM   = 19;
   localparam int UNIT_PRINT  = 18;
   localparam int WORDS_TERM  = 14;
   localparam int WORDS_PRINT = 24;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_SEND  = 3'd2;
   localparam logic [2:0] ST_CR    = 3'd3;
   localparam logic [2:0] ST_LF    = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   // Inverse of the IN unit's table; unassigned codes print as a space.
   function automatic logic [7:0] mix_to_ascii(input logic [5:0] c);
      logic [7:0] a;
      a = ASCII_SPACE;
      if (c >= 6'd1 && c <= 6'd9)
         a = 8'h40 + {2'b00, c};          // A..I
      else if (c >= 6'd11 && c <= 6'd19)
         a = 8'h3F + {2'b00, c};          // J..R
      else if (c >= 6'd22 && c <= 6'd29)
         a = 8'h3D + {2'b00, c};          // S..Z
      else if (c >= 6'd30 && c <= 6'd39)
         a = 8'h12 + {2'b00, c};          // 0..9
      else begin
         case (c)
            6'd40: a = 8'h2E;  // .
            6'd41: a = 8'h2C;  // ,
            6'd42: a = 8'h28;  // (
            6'd43: a = 8'h29;  // )
            6'd44: a = 8'h2B;  // +
            6'd45: a = 8'h2D;  // -
            6'd46: a = 8'h2A;  // *
            6'd47: a = 8'h2F;  // /
            6'd48: a = 8'h3D;  // =
            6'd49: a = 8'h24;  // $
            6'd50: a = 8'h3C;  // <
            6'd51: a = 8'h3E;  // >
            6'd52: a = 8'h40;  // @
            6'd53: a = 8'h3B;  // ;
            6'd54: a = 8'h3A;  // :
            6'd55: a = 8'h27;  // '
            default: a = ASCII_SPACE;
         endcase
      end
      return a;
   endfunction

endpackage

// File: rtl/out_unit_if.sv
// CPU I/O bus between the CPU (master) and the output unit (slave).
// Carries the OUT strobe, block address, word fetch handshake and status.
interface out_unit_if;
   logic        start;
   logic [5:0]  field;
   logic [11:0] addressin;
   logic [11:0] addressout;
   logic        request;
   logic        load;
   logic [29:0] in;
   logic        stop;
   logic        busy;

   modport master (
      output start, field, addressin, load, in,
      input  addressout, request, stop, busy
   );

   modport slave (
      input  start, field, addressin, load, in,
      output addressout, request, stop, busy
   );
endinterface

// File: rtl/out_unit_uart_tx.sv
// UART transmitter, 8N1, LSB first.
// Latency: start bit drives tx on the clock after valid & ready.
// Backpressure: ready is low for the whole frame, high again one cycle after the stop bit.
module uart_tx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);

   logic          active;
   logic [CW-1:0] clk_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shreg;

   assign ready = ~active;

   // Frame sequencer: start bit on accept, then 8 data bits and the stop bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active  <= 1'b0;
         clk_cnt <= '0;
         bit_cnt <= 4'd0;
         shreg   <= '1;
         tx      <= 1'b1;
      end else if (!active) begin
         if (valid) begin
            active  <= 1'b1;
            tx      <= 1'b0;
            shreg   <= {1'b1, data};
            bit_cnt <= 4'd0;
            clk_cnt <= '0;
         end
      end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
         clk_cnt <= '0;
         if (bit_cnt == 4'd9) begin
            active <= 1'b0;
         end else begin
            tx      <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else begin
         clk_cnt <= clk_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/out_unit.sv
// MIX output unit: fetches a block of words and prints them as ASCII, then CR LF.
// Latency: stop pulses one cycle after an accepted start; first request the same cycle busy rises.
// Backpressure: request holds until load; characters wait for the UART to become ready.
import out_unit_pkg::*;

module out_unit #(
   parameter int CLKS_PER_BIT = 104,
   parameter int TERM_UNIT    = UNIT_TERM,
   parameter int PRINT_UNIT   = UNIT_PRINT,
   parameter int TERM_WORDS   = WORDS_TERM,
   parameter int PRINT_WORDS  = WORDS_PRINT
) (
   input  logic       clk,
   input  logic       reset,
   out_unit_if.slave  bus,
   output logic       tx
);
   logic [2:0]  state;
   logic [5:0]  unit;
   logic [11:0] addressout;
   logic [11:0] next_addr;
   logic        request;
   logic        stop;
   logic        busy;
   logic        pend;
   logic [29:0] word;
   logic [2:0]  char_cnt;
   logic [4:0]  word_cnt;
   logic [4:0]  blk_len;
   logic [4:0]  start_len;
   logic        tx_vld;
   logic        tx_rdy;
   logic [7:0]  tx_dat;
   logic        tx_acc;

   // Unknown units get length zero and finish without touching memory.
   function automatic logic [4:0] len_for(input logic [5:0] u);
      logic [4:0] n;
      if (u == 6'(TERM_UNIT))
         n = 5'(TERM_WORDS);
      else if (u == 6'(PRINT_UNIT))
         n = 5'(PRINT_WORDS);
      else
         n = 5'd0;
      return n;
   endfunction

   assign bus.addressout = addressout;
   assign bus.request    = request;
   assign bus.stop       = stop;
   assign bus.busy       = busy;

   // Block length of the latched unit and of the unit on the bus.
   always_comb begin
      blk_len   = len_for(unit);
      start_len = len_for(bus.field);
   end

   // Character source for the UART: top char of the word, or CR / LF.
   always_comb begin
      tx_vld = 1'b0;
      tx_dat = mix_to_ascii(word[29:24]);
      case (state)
         ST_SEND: tx_vld = 1'b1;
         ST_CR: begin
            tx_vld = 1'b1;
            tx_dat = ASCII_CR;
         end
         ST_LF: begin
            tx_vld = 1'b1;
            tx_dat = ASCII_LF;
         end
         default: tx_vld = 1'b0;
      endcase
   end

   assign tx_acc = tx_vld & tx_rdy;

   // Control FSM: fetch words, feed characters, close the line, chain a pending block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         unit       <= 6'd0;
         addressout <= 12'd0;
         next_addr  <= 12'd0;
         request    <= 1'b0;
         stop       <= 1'b0;
         busy       <= 1'b0;
         pend       <= 1'b0;
         word       <= 30'd0;
         char_cnt   <= 3'd0;
         word_cnt   <= 5'd0;
      end else begin
         stop <= 1'b0;
         // A start while busy queues one more block; the CPU stays stalled.
         if (bus.start && busy && !pend) begin
            next_addr <= bus.addressin;
            pend      <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  unit       <= bus.field;
                  addressout <= bus.addressin;
                  busy       <= 1'b1;
                  stop       <= 1'b1;
                  word_cnt   <= 5'd0;
                  if (start_len == 5'd0) begin
                     state <= ST_DONE;
                  end else begin
                     request <= 1'b1;
                     state   <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               if (bus.load && request) begin
                  word       <= bus.in;
                  request    <= 1'b0;
                  addressout <= addressout + 12'd1;
                  char_cnt   <= 3'd0;
                  state      <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_acc) begin
                  word     <= {word[23:0], 6'd0};
                  char_cnt <= char_cnt + 3'd1;
                  if (char_cnt == 3'd4) begin
                     word_cnt <= word_cnt + 5'd1;
                     if (word_cnt + 5'd1 == blk_len) begin
                        state <= ST_CR;
                     end else begin
                        request <= 1'b1;
                        state   <= ST_FETCH;
                     end
                  end
               end
            end
            ST_CR: begin
               if (tx_acc) state <= ST_LF;
            end
            ST_LF: begin
               if (tx_acc) state <= ST_DONE;
            end
            ST_DONE: begin
               // A start landing in this very cycle counts as the pending block.
               if (pend || bus.start) begin
                  addressout <= pend ? next_addr : bus.addressin;
                  pend       <= 1'b0;
                  stop       <= 1'b1;
                  word_cnt   <= 5'd0;
                  if (blk_len != 5'd0) begin
                     request <= 1'b1;
                     state   <= ST_FETCH;
                  end
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk   (clk),
      .reset (reset),
      .data  (tx_dat),
      .valid (tx_vld),
      .ready (tx_rdy),
      .tx    (tx)
   );
endmodule
